// File: rtl/data_write_buffer.sv
// data_write_buffer
//   Posted-store buffer between the CPU MEM stage and the data cache /
//   memory controller. CPU stores are queued in a small FIFO and drained
//   to the controller one at a time, in order. Loads wait until every
//   older store has drained, so memory order is preserved.
//
//   Optional build macro: DATA_WRITE_BUFFER_STORE_FWD_EN
//     When defined, a word load that hits a queued word store (youngest
//     match wins) is answered straight from the FIFO. No drain and no
//     controller access take place.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   addr, write_data    CPU byte address / store data
//   memwrite, memread   CPU store / load request (held while clk_stall=1)
//   sign_mask           access size/sign: [3]=signed, [2:0]=111/011/001
//   read_data           load result, valid in the cycle clk_stall falls
//   clk_stall           combinational CPU stall
//   mem_addr, mem_write_data, mem_sign_mask  registered request fields
//   mem_memwrite, mem_memread                one-cycle request strobes
//   mem_read_data       controller load result
//   mem_clk_stall       controller busy (rises the cycle after a strobe)
//
// FSM states
//   IDLE      | pick the next job: drain the FIFO head, else issue a load
//   WAIT_ACK  | strobe sent, waiting for mem_clk_stall to rise
//   WAIT_DONE | controller busy, waiting for mem_clk_stall to fall
//   RESP      | load result presented to the CPU for one cycle
module data_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        clk_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE, RESP} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    state_t state, state_next;

    logic [31:0] fifo_addr [DEPTH];
    logic [31:0] fifo_data [DEPTH];
    logic [3:0]  fifo_mask [DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_full, fifo_empty;

    logic op_is_read;
    logic load_done;
    logic load_req;
    logic push, pop;
    logic issue_write, issue_read, capture, fwd_take;
    logic fwd_hit;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // A load is pending until its result has been presented for one cycle.
    assign load_req = memread & ~load_done;

    // A store is ignored when memread is also asserted. When the FIFO is
    // full the store may still go in on the cycle the head is popped.
    assign push = memwrite & ~memread & (~fifo_full | pop);

    assign clk_stall = ~reset & (load_req | (memwrite & ~memread & fifo_full & ~pop));

`ifdef DATA_WRITE_BUFFER_STORE_FWD_EN
    logic [31:0]      fwd_data;
    logic             fwd_match, fwd_word;
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_match = 1'b0;
        fwd_word  = 1'b0;
        fwd_data  = '0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count) && (fifo_addr[fwd_idx][31:2] == addr[31:2])) begin
                fwd_match = 1'b1;
                fwd_word  = (fifo_mask[fwd_idx][2:0] == 3'b111);
                fwd_data  = fifo_data[fwd_idx];
            end
        end
        fwd_hit = fwd_match & fwd_word & (sign_mask[2:0] == 3'b111);
    end
`else
    assign fwd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        issue_write = 1'b0;
        issue_read  = 1'b0;
        capture     = 1'b0;
        fwd_take    = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (load_req && fwd_hit) begin
                    // Forwarding needs no controller, so it does not wait on mem_clk_stall.
                    fwd_take   = 1'b1;
                    state_next = RESP;
                end else if (!mem_clk_stall) begin
                    if (!fifo_empty) begin
                        issue_write = 1'b1;
                        state_next  = WAIT_ACK;
                    end else if (load_req) begin
                        issue_read = 1'b1;
                        state_next = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (mem_clk_stall) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!mem_clk_stall) begin
                    if (op_is_read) begin
                        capture    = 1'b1;
                        state_next = RESP;
                    end else begin
                        pop        = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= addr;
            fifo_data[wr_ptr] <= write_data;
            fifo_mask[wr_ptr] <= sign_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            op_is_read     <= 1'b0;
            load_done      <= 1'b0;
            read_data      <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
            mem_memwrite   <= 1'b0;
            mem_memread    <= 1'b0;
        end else begin
            mem_memwrite <= 1'b0;
            mem_memread  <= 1'b0;

            if (issue_write) begin
                mem_addr       <= fifo_addr[rd_ptr];
                mem_write_data <= fifo_data[rd_ptr];
                mem_sign_mask  <= fifo_mask[rd_ptr];
                mem_memwrite   <= 1'b1;
                op_is_read     <= 1'b0;
            end else if (issue_read) begin
                mem_addr      <= addr;
                mem_sign_mask <= sign_mask;
                mem_memread   <= 1'b1;
                op_is_read    <= 1'b1;
            end

            if (capture) begin
                read_data <= mem_read_data;
            end
`ifdef DATA_WRITE_BUFFER_STORE_FWD_EN
            if (fwd_take) begin
                read_data <= fwd_data;
            end
`endif
            load_done <= capture | fwd_take;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_write_buffer.sv
module tb_data_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, write_data;
    logic        memwrite, memread;
    logic [3:0]  sign_mask;
    logic [31:0] read_data;
    logic        clk_stall;
    logic [31:0] mem_addr, mem_write_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memwrite, mem_memread;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    data_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
        .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
        .read_data(read_data), .clk_stall(clk_stall),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_sign_mask(mem_sign_mask), .mem_memwrite(mem_memwrite),
        .mem_memread(mem_memread), .mem_read_data(mem_read_data),
        .mem_clk_stall(mem_clk_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } wr_t;

    int checks = 0;
    int failures = 0;
    wr_t         exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ctl_mem [logic [31:0]];
    int  wr_strobes = 0, rd_strobes = 0;
    int  cyc = 0, last_wr_cyc = 0, last_rd_cyc = 0;
    int  ctrl_lat = 2;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] k);
        return k ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] k = {a[31:2], 2'b00};
        if (ref_mem.exists(k)) return ref_mem[k];
        return dflt(k);
    endfunction

    function automatic logic [31:0] ctl_rd(input logic [31:0] a);
        logic [31:0] k = {a[31:2], 2'b00};
        if (ctl_mem.exists(k)) return ctl_mem[k];
        return dflt(k);
    endfunction

    // Controller model: busy from the cycle after a strobe for ctrl_lat cycles.
    initial begin
        logic [31:0] a;
        bit rd;
        mem_clk_stall = 1'b0;
        mem_read_data = '0;
        forever begin
            @(negedge clk);
            if (mem_memwrite || mem_memread) begin
                a  = mem_addr;
                rd = mem_memread;
                if (mem_memwrite) ctl_mem[{a[31:2], 2'b00}] = mem_write_data;
                @(posedge clk); #1;
                mem_clk_stall = 1'b1;
                repeat (ctrl_lat) @(posedge clk);
                #1;
                mem_clk_stall = 1'b0;
                if (rd) mem_read_data = ctl_rd(a);
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        wr_t e;
        logic [31:0] r;
        bit prev_wr = 0, prev_rd = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_memwrite) begin
                wr_strobes++;
                last_wr_cyc = cyc;
                if (exp_wr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write actual=%h required=none", mem_addr);
                end else begin
                    e = exp_wr_q.pop_front();
                    chk(mem_addr == e.a, "wr_addr", mem_addr, e.a);
                    chk(mem_write_data == e.d, "wr_data", mem_write_data, e.d);
                    chk(mem_sign_mask == e.m, "wr_mask", {28'd0, mem_sign_mask}, {28'd0, e.m});
                end
            end
            if (mem_memread) begin
                rd_strobes++;
                last_rd_cyc = cyc;
            end
            if ((mem_memwrite || mem_memread) && mem_clk_stall) begin
                checks++; failures++;
                $display("FAIL strobe_while_busy actual=1 required=0");
            end
            if ((mem_memwrite && prev_wr) || (mem_memread && prev_rd)) begin
                checks++; failures++;
                $display("FAIL strobe_width actual=2+ required=1");
            end
            prev_wr = mem_memwrite;
            prev_rd = mem_memread;
            if (memread && !clk_stall && !reset) begin
                if (exp_rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_load actual=%h required=none", read_data);
                end else begin
                    r = exp_rd_q.pop_front();
                    chk(read_data == r, "load_data", read_data, r);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                               output int stalls);
        bit acc = 0;
        wr_t e;
        memwrite = 1'b1; memread = 1'b0;
        addr = a; write_data = d; sign_mask = m;
        stalls = 0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            if (!clk_stall) acc = 1; else stalls++;
            step();
        end
        memwrite = 1'b0;
        if (acc) begin
            e.a = a; e.d = d; e.m = m;
            exp_wr_q.push_back(e);
            ref_mem[{a[31:2], 2'b00}] = d;
        end else begin
            checks++; failures++;
            $display("FAIL store_timeout actual=%h required=accepted", a);
        end
    endtask

    task automatic issue_load(input logic [31:0] a, input logic [3:0] m, input bit both,
                              output int stalls);
        bit acc = 0;
        exp_rd_q.push_back(ref_rd(a));
        memread = 1'b1; memwrite = both;
        addr = a; sign_mask = m; write_data = $urandom;
        stalls = 0;
        for (int n = 0; n < 400 && !acc; n++) begin
            @(negedge clk);
            if (!clk_stall) acc = 1; else stalls++;
            step();
        end
        memread = 1'b0; memwrite = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL load_timeout actual=%h required=done", a);
        end
    endtask

    task automatic wait_quiet();
        int q = 0;
        for (int n = 0; n < 1000 && q < 3; n++) begin
            step();
            if (exp_wr_q.size() == 0 && !mem_clk_stall && !mem_memwrite && !mem_memread) q++;
            else q = 0;
        end
        if (q < 3) begin
            checks++; failures++;
            $display("FAIL quiet_timeout actual=busy required=idle");
        end
    endtask

    task automatic check_outputs_zero(input string name);
        @(negedge clk);
        chk({read_data, clk_stall, mem_addr, mem_write_data, mem_sign_mask, mem_memwrite, mem_memread} == '0,
            name, mem_addr | read_data, 32'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, bw, br;
        int s[5];
        logic [3:0] wm [4] = '{4'b0111, 4'b0011, 4'b0001, 4'b1011};
        logic [3:0] lm [4] = '{4'b0111, 4'b0111, 4'b1011, 4'b0011};
        ref_mem[32'h200] = 32'hDEAD_BEEF;
        ctl_mem[32'h200] = 32'hDEAD_BEEF;

        // Reset with a store held on the bus.
        reset = 1'b1; memread = 1'b0; memwrite = 1'b1;
        addr = 32'h100; write_data = 32'hA0; sign_mask = 4'b0111;
        for (int i = 0; i < 3; i++) check_outputs_zero("reset_outputs");
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'b0111, st);
            chk(st == 0, "store_no_stall", st, 0);
        end
        bw = wr_strobes;
        wait_quiet();
        chk(wr_strobes == 4, "drain_count", wr_strobes, 4);

        // Five stores against a slow controller: fifth waits for the first pop.
        ctrl_lat = 6;
        for (int i = 0; i < 5; i++)
            issue_store(32'h500 + 32'(4 * i), 32'h5000 + 32'(i), 4'b0111, s[i]);
        for (int i = 0; i < 4; i++) chk(s[i] == 0, "full_first4", s[i], 0);
        chk(s[4] == ctrl_lat - 1, "full_fifth_stall", s[4], ctrl_lat - 1);
        wait_quiet();

        // Load with controller latency 3 into an empty FIFO.
        ctrl_lat = 2;
        br = rd_strobes;
        issue_load(32'h200, 4'b0111, 0, st);
        chk(st == 5, "load_latency", st, 5);
        step(); step();
        chk(rd_strobes - br == 1, "load_one_strobe", rd_strobes - br, 1);

        // Store then load to the same word.
        wait_quiet();
        bw = wr_strobes; br = rd_strobes;
        issue_store(32'h300, 32'h1122_3344, 4'b0111, st);
        issue_load(32'h300, 4'b0111, 0, st);
        wait_quiet();
        chk(wr_strobes - bw == 1, "sw_lw_write", wr_strobes - bw, 1);
`ifdef DATA_WRITE_BUFFER_STORE_FWD_EN
        chk(st == 1, "fwd_stall", st, 1);
        chk(rd_strobes == br, "fwd_no_read", rd_strobes - br, 0);
`else
        chk(rd_strobes - br == 1, "sw_lw_read", rd_strobes - br, 1);
        chk(last_wr_cyc < last_rd_cyc, "store_before_load", last_wr_cyc, last_rd_cyc);
`endif

        // memread and memwrite together: load only.
        bw = wr_strobes;
        issue_load(32'h400, 4'b0111, 1, st);
        wait_quiet();
        chk(wr_strobes == bw, "both_no_store", wr_strobes - bw, 0);

        // Reset while the controller is busy with a store.
        ctrl_lat = 10;
        issue_store(32'h600, 32'h6666_0000, 4'b0111, st);
        for (int n = 0; n < 50 && !mem_clk_stall; n++) step();
        chk(mem_clk_stall == 1'b1, "busy_seen", {31'd0, mem_clk_stall}, 1);
        step(); step();
        reset = 1'b1;
        step();
        check_outputs_zero("midreset_outputs");
        step();
        reset = 1'b0;
        bw = wr_strobes; br = rd_strobes;
        repeat (20) step();
        chk(wr_strobes == bw && rd_strobes == br, "reset_no_strobe", wr_strobes - bw, 0);
        ctrl_lat = 2;
        issue_store(32'h604, 32'h6666_0004, 4'b0111, st);
        wait_quiet();
        chk(wr_strobes - bw == 1, "after_reset_store", wr_strobes - bw, 1);

        // Randomised mix against the reference memory.
        for (int i = 0; i < 120; i++) begin
            int r = $urandom_range(0, 9);
            logic [31:0] a = 32'h700 + 32'(4 * $urandom_range(0, 5));
            ctrl_lat = $urandom_range(1, 4);
            if (r < 5) issue_store(a, $urandom, wm[$urandom_range(0, 3)], st);
            else if (r < 8) issue_load(a, lm[$urandom_range(0, 3)], 0, st);
            else if (r == 8) issue_load(a, 4'b0111, 1, st);
            else step();
        end
        wait_quiet();
        chk(exp_wr_q.size() == 0, "wr_queue_empty", exp_wr_q.size(), 0);
        chk(exp_rd_q.size() == 0, "rd_queue_empty", exp_rd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_write_buffer.md
Name: data_write_buffer

Overview:
- Posted-store buffer between the CPU MEM stage and the data cache/memory controller.
- Queues CPU stores in a small FIFO so store instructions do not stall the pipeline.
- Drains stores to the controller one at a time, in order.
- Serialises loads behind pending stores, so memory order is preserved.
- Talks to the controller with single-cycle request strobes and watches the controller's stall line for completion.

Parameters:
- DEPTH, 4: number of store entries (power of two, >=2).
- PTR_W, 2: log2(DEPTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  CPU byte address.
- write_data  in  32  CPU store data.
- memwrite  in  1  CPU store request; held while clk_stall=1.
- memread  in  1  CPU load request; held while clk_stall=1.
- sign_mask  in  4  access size/sign: [3]=signed, [2:0]=111 word, 011 half, 001 byte.
- read_data  out  32  load result; valid in the cycle clk_stall falls after a load.
- clk_stall  out  1  combinational CPU stall.
- mem_addr  out  32  registered request address to controller.
- mem_write_data  out  32  registered request data.
- mem_sign_mask  out  4  registered request size.
- mem_memwrite  out  1  one-cycle write strobe.
- mem_memread  out  1  one-cycle read strobe.
- mem_read_data  in  32  controller load result.
- mem_clk_stall  in  1  controller busy; rises the cycle after a strobe, falls when done.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, load_done=0. Reset mid-transaction abandons it.
- After reset, the block issues no strobe while mem_clk_stall=1.
- Store accept: at posedge with memwrite=1, memread=0, count<DEPTH → push {addr, write_data, sign_mask}. No stall.
- Full FIFO: memwrite=1 with count==DEPTH → clk_stall=1 until a pop frees an entry; the store is pushed on that cycle.
- Simultaneous push and pop: count unchanged.
- Load:
  - clk_stall = memread & ~load_done (OR the full-store term above).
  - A load waits until the FIFO is empty, then issues.
  - When the result is captured, load_done pulses for 1 cycle. In that cycle clk_stall=0 and read_data holds the captured value.
  - The next cycle's memread is treated as a new instruction.
- memread and memwrite both 1: load handling only; the store is ignored.
- FSM:
  - IDLE: if FIFO non-empty (and no forward hit, see Optional Feature) → register head onto mem_*, mem_memwrite=1, go WAIT_ACK. Else if memread & ~load_done → register CPU addr/sign_mask, mem_memread=1, go WAIT_ACK.
  - WAIT_ACK: strobes cleared (each strobe high exactly one cycle). Go WAIT_DONE when mem_clk_stall=1.
  - WAIT_DONE: when mem_clk_stall=0 → for a write, pop and go IDLE; for a read, read_data<=mem_read_data, load_done<=1, go RESP.
  - RESP: 1 cycle; load_done<=0, go IDLE.
- Latency: load into an empty FIFO with controller read latency of 3 → memread first seen in cycle 0, stall cycles 0–4, clk_stall=0 with data in cycle 5.
- Store drain: ~4 cycles per entry, back-to-back.
- Pointers wrap modulo DEPTH; count is PTR_W+1 bits.
- No timeout: a stuck mem_clk_stall hangs the FSM by design.

Optional Feature:
- Macro: DATA_WRITE_BUFFER_STORE_FWD_EN.
- Defined:
  - In IDLE, a word load (sign_mask[2:0]=111) searches the FIFO youngest-first for addr[31:2] matches.
  - If the youngest match is a word store: read_data<=its data, go RESP directly. No drain, no controller access; clk_stall is high for exactly 1 cycle.
  - Any other match, or a non-word load, drains as in the base behaviour.
- Undefined: no comparators; every load drains first.

Test Plan:
- Reset with memwrite=1 held → no push, all outputs 0; after release the FIFO accepts 1 store per cycle with clk_stall=0.
- 4 stores to 0x100..0x10C (data 0xA0..0xA3) back-to-back → no CPU stall; controller sees 4 single-cycle mem_memwrite strobes, in order, with matching addr/data.
- 5 back-to-back stores with a slow controller → clk_stall=1 on the 5th until the first pop; 5th entry pushed that cycle.
- Load from 0x200, empty FIFO, controller returns 0xDEADBEEF → stall cycles 0–4, cycle 5 clk_stall=0 and read_data=0xDEADBEEF; exactly one mem_memread pulse.
- sw 0x11223344 to 0x300, then lw 0x300:
  - FWD undefined → store drains first, then the read strobe.
  - FWD defined → read_data=0x11223344 after 1 stall cycle, no mem_memread.
- Assert reset during WAIT_DONE with mem_clk_stall=1 → state IDLE, FIFO empty, no strobe until mem_clk_stall=0.
